// File: rtl/conv_wm_sram_stream_if.sv
// Command, write-stream and read-stream bundle for the conv-layer weight memory.
// master = layer controller / PE side, slave = the memory block.
interface conv_wm_sram_stream_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 7,
  parameter int WMASK_WIDTH = DATA_WIDTH / 8
);
  logic                   cfg_start;
  logic                   cfg_mode;
  logic [ADDR_WIDTH-1:0]  cfg_base;
  logic [ADDR_WIDTH:0]    cfg_len;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [WMASK_WIDTH-1:0] wr_wmask;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_perr;

  modport master (
    output cfg_start, cfg_mode, cfg_base, cfg_len, wr_valid, wr_data, wr_wmask, rd_ready,
    input  busy, done, cfg_err, wr_ready, rd_valid, rd_data, rd_perr
  );

  modport slave (
    input  cfg_start, cfg_mode, cfg_base, cfg_len, wr_valid, wr_data, wr_wmask, rd_ready,
    output busy, done, cfg_err, wr_ready, rd_valid, rd_data, rd_perr
  );
endinterface

// File: rtl/conv_wm_sram_stream.sv
// Single-port weight memory: masked write bursts in, backpressured read bursts out through a
// 2-entry FIFO that hides the 1-cycle read latency. Optional macro MEM_PARITY_EN adds word parity.
module conv_wm_sram_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 100,
  parameter int ADDR_WIDTH  = 7,
  parameter int WMASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk0,
  input  logic                    rst0_n,
  conv_wm_sram_stream_if.slave    bus
);
  localparam int LEN_W = ADDR_WIDTH + 1;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ} state_t;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0]  old_w,
                                                        input logic [DATA_WIDTH-1:0]  new_w,
                                                        input logic [WMASK_WIDTH-1:0] mask);
    logic [DATA_WIDTH-1:0] m;
    m = old_w;
    for (int i = 0; i < WMASK_WIDTH; i++)
      if (mask[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

  function automatic logic [MEM_W-1:0] encode_word(input logic [DATA_WIDTH-1:0] d);
`ifdef MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0]      mem [DEPTH];
  state_t                state, state_nxt;
  logic                  done_nxt, err_nxt, done_q, err_q;
  logic [ADDR_WIDTH-1:0] ptr, ptr_inc;
  logic [LEN_W-1:0]      left_a, left_b;
  logic [1:0]            fifo_cnt;
  logic                  wptr, rptr;
  logic [DATA_WIDTH-1:0] fifo_d_p1 [2];
  logic                  fifo_p_p1 [2];
  logic [MEM_W-1:0]      rword;
  logic [DATA_WIDTH-1:0] rdata_w;
  logic                  rperr_w;
  logic                  cmd_ok, accept, wr_fire, vld_p0, pop, last_wr, last_pop;

  assign rword   = mem[ptr];
  assign rdata_w = rword[DATA_WIDTH-1:0];
`ifdef MEM_PARITY_EN
  assign rperr_w = ^rword;
`else
  assign rperr_w = 1'b0;
`endif

  assign cmd_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(DEPTH)) &&
                    (bus.cfg_base < ADDR_WIDTH'(DEPTH));
  assign accept   = (state == S_IDLE) && bus.cfg_start && cmd_ok;
  assign ptr_inc  = (ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign wr_fire  = (state == S_LOAD) && bus.wr_valid;
  assign pop      = (fifo_cnt != 2'd0) && bus.rd_ready;
  // Reads whose data would land while the FIFO is full are allowed only if a pop frees a slot.
  assign vld_p0   = (state == S_READ) && (left_a != '0) && ((fifo_cnt < 2'd2) || pop);
  assign last_wr  = wr_fire && (left_a == LEN_W'(1));
  assign last_pop = pop && (left_b == LEN_W'(1));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: if (bus.cfg_start) begin
        if (cmd_ok) state_nxt = bus.cfg_mode ? S_READ : S_LOAD;
        else        err_nxt   = 1'b1;
      end
      S_LOAD: if (last_wr)  begin state_nxt = S_IDLE; done_nxt = 1'b1; end
      S_READ: if (last_pop) begin state_nxt = S_IDLE; done_nxt = 1'b1; end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      state    <= S_IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ptr      <= '0;
      left_a   <= '0;
      left_b   <= '0;
      fifo_cnt <= 2'd0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      if (accept) begin
        ptr    <= bus.cfg_base;
        left_a <= bus.cfg_len;
        left_b <= bus.cfg_len;
      end else if (wr_fire || vld_p0) begin
        ptr    <= ptr_inc;
        left_a <= left_a - 1'b1;
      end
      if (pop) begin
        left_b <= left_b - 1'b1;
        rptr   <= ~rptr;
      end
      if (vld_p0) wptr <= ~wptr;
      fifo_cnt <= fifo_cnt + 2'(vld_p0) - 2'(pop);
    end
  end

  // p0 -> p1: SRAM access; read data lands directly in the FIFO slot
  always_ff @(posedge clk0) begin
    if (wr_fire) mem[ptr] <= encode_word(merge_bytes(rdata_w, bus.wr_data, bus.wr_wmask));
    if (vld_p0) begin
      fifo_d_p1[wptr] <= rdata_w;
      fifo_p_p1[wptr] <= rperr_w;
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.cfg_err  = err_q;
  assign bus.wr_ready = (state == S_LOAD);
  assign bus.rd_valid = (fifo_cnt != 2'd0);
  assign bus.rd_data  = bus.rd_valid ? fifo_d_p1[rptr] : '0;
  assign bus.rd_perr  = bus.rd_valid & fifo_p_p1[rptr];
endmodule

// File: tb/tb_conv_wm_sram_stream.sv
// Directed bench for conv_wm_sram_stream: reset, full load/readback, wrap, byte mask,
// backpressure, command errors and reset mid-burst.
module tb_conv_wm_sram_stream;
  logic clk0 = 1'b0;
  logic rst0_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [15:0] wq[$];
  logic [15:0] got_q[$];
  logic        got_p[$];

  always #5 clk0 = ~clk0;

  conv_wm_sram_stream_if #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .WMASK_WIDTH(2)) bus ();

  conv_wm_sram_stream #(.DATA_WIDTH(16), .DEPTH(100), .ADDR_WIDTH(7), .WMASK_WIDTH(2)) dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input logic mode, input logic [6:0] base, input int len);
    bus.cfg_mode  = mode;
    bus.cfg_base  = base;
    bus.cfg_len   = 8'(len);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic load_burst(input logic [6:0] base, input int len, input logic [1:0] mask);
    issue_cmd(1'b0, base, len);
    check("ld_busy", bus.busy, 1);
    check("ld_wr_ready", bus.wr_ready, 1);
    for (int i = 0; i < len; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = wq[i];
      bus.wr_wmask = mask;
      tick();
    end
    bus.wr_valid = 1'b0;
    check("ld_done", bus.done, 1);
    check("ld_wr_ready_off", bus.wr_ready, 0);
    tick();
    check("ld_done_once", bus.done, 0);
  endtask

  task automatic read_burst(input logic [6:0] base, input int len, input bit rnd);
    int first_k, last_k, dones;
    bit stalled, occ_ok;
    logic [15:0] held;
    got_q.delete();
    got_p.delete();
    first_k = -1; last_k = -1; dones = 0; stalled = 0; occ_ok = 1; held = '0;
    bus.rd_ready = rnd ? 1'b0 : 1'b1;
    issue_cmd(1'b1, base, len);
    for (int k = 0; k < 400; k++) begin
      if (rnd) bus.rd_ready = 1'($urandom_range(0, 1));
      if (stalled) begin
        check("stall_valid", bus.rd_valid, 1);
        check("stall_data", bus.rd_data, held);
      end
      if (bus.done) begin dones++; break; end
      if (dut.fifo_cnt > 2'd2) occ_ok = 0;
      if (bus.rd_valid && first_k < 0) first_k = k;
      if (bus.rd_valid && bus.rd_ready) begin
        got_q.push_back(bus.rd_data);
        got_p.push_back(bus.rd_perr);
        last_k = k;
      end
      stalled = bus.rd_valid && !bus.rd_ready;
      held    = bus.rd_data;
      tick();
    end
    check("rd_count", got_q.size(), len);
    check("rd_done", dones, 1);
    check("rd_busy_after", bus.busy, 0);
    check("rd_occ_le2", occ_ok, 1);
    if (!rnd) begin
      check("rd_first_latency", first_k, 1);
      check("rd_sustain", last_k, len);
    end
    tick();
    check("rd_done_once", bus.done, 0);
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    rst0_n = 1'b0;
    bus.cfg_start = 0; bus.cfg_mode = 0; bus.cfg_base = '0; bus.cfg_len = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.wr_wmask = '0; bus.rd_ready = 0;

    // 1. reset
    tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_perr", bus.rd_perr, 0);
    check("rst_rd_data", bus.rd_data, 0);
    rst0_n = 1'b1;
    tick();

    // 2. full load and streaming readback
    wq.delete();
    for (int i = 0; i < 100; i++) wq.push_back(16'h1000 + 16'(i));
    load_burst(7'd0, 100, 2'b11);
    read_burst(7'd0, 100, 1'b0);
    for (int i = 0; i < 100; i++) check("full_word", got_q[i], 16'h1000 + 16'(i));

    // 3. address wrap 98,99,0,1
    wq.delete();
    wq.push_back(16'hA11A); wq.push_back(16'hB22B); wq.push_back(16'hC33C); wq.push_back(16'hD44D);
    load_burst(7'd98, 4, 2'b11);
    read_burst(7'd98, 4, 1'b0);
    check("wrap_w0", got_q[0], 16'hA11A);
    check("wrap_w1", got_q[1], 16'hB22B);
    check("wrap_w2", got_q[2], 16'hC33C);
    check("wrap_w3", got_q[3], 16'hD44D);
    read_burst(7'd0, 2, 1'b0);
    check("wrap_addr0", got_q[0], 16'hC33C);
    check("wrap_addr1", got_q[1], 16'hD44D);

    // 4. byte mask
    wq.delete(); wq.push_back(16'hAAAA);
    load_burst(7'd5, 1, 2'b11);
    wq.delete(); wq.push_back(16'h5555);
    load_burst(7'd5, 1, 2'b01);
    read_burst(7'd5, 1, 1'b0);
    check("mask_lo", got_q[0], 16'hAA55);
    wq.delete(); wq.push_back(16'h1234);
    load_burst(7'd5, 1, 2'b10);
    read_burst(7'd5, 1, 1'b0);
    check("mask_hi", got_q[0], 16'h1255);

    // 5. random backpressure
    read_burst(7'd10, 10, 1'b1);
    for (int i = 0; i < 10; i++) check("bp_word", got_q[i], 16'h1000 + 16'(10 + i));

    // 6. rejected commands
    issue_cmd(1'b1, 7'd0, 0);
    check("err_len0", bus.cfg_err, 1);
    check("err_len0_busy", bus.busy, 0);
    tick();
    check("err_pulse_end", bus.cfg_err, 0);
    issue_cmd(1'b0, 7'd0, 101);
    check("err_len101", bus.cfg_err, 1);
    check("err_len101_busy", bus.busy, 0);
    tick();
    issue_cmd(1'b1, 7'd100, 1);
    check("err_base100", bus.cfg_err, 1);
    check("err_base100_busy", bus.busy, 0);
    tick();

    // start while busy is ignored
    bus.rd_ready = 1'b0;
    issue_cmd(1'b1, 7'd40, 3);
    bus.cfg_base = 7'd100; bus.cfg_len = '0; bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("busy_start_no_err", bus.cfg_err, 0);
    check("busy_start_busy", bus.busy, 1);
    tick();
    check("busy_start_no_err2", bus.cfg_err, 0);

    // reset mid-READ
    rst0_n = 1'b0;
    tick();
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    rst0_n = 1'b1;
    tick();
    check("midrst_no_done", bus.done, 0);
    read_burst(7'd20, 5, 1'b0);
    for (int i = 0; i < 5; i++) check("post_rst_word", got_q[i], 16'h1000 + 16'(20 + i));
    check("post_rst_perr", got_p[0], 0);

`ifdef MEM_PARITY_EN
    dut.mem[30] = dut.mem[30] ^ 17'h00001;
    read_burst(7'd29, 3, 1'b0);
    check("par_w29", got_p[0], 0);
    check("par_w30", got_p[1], 1);
    check("par_w31", got_p[2], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
